uart_rx_loader: RTL and testbench
=================================

Name: uart_rx_loader

Overview:
Serial program/data loader feeding the memory block's 8-bit rx_data input.
- Deserialises an 8N1 UART line into bytes.
- Packs bytes little-endian into 32-bit words.
- Emits word-write strobes with an incrementing word index, so the host can fill instruction/data memory before or while the core runs.
- Runs on the free-running clk, not the ready-gated core clock.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
ADDR_W, 8, width of the word index; wraps at 2**ADDR_W.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
rxd  input  1  raw UART line, idle high, asynchronous to clk.
rx_data  output  8  last good byte received; holds until the next good byte.
rx_valid  output  1  one-cycle pulse when rx_data updates.
frame_err  output  1  one-cycle pulse on a bad stop bit.
word_data  output  32  assembled word {b3,b2,b1,b0}; b0 is the first byte received.
word_valid  output  1  one-cycle pulse when word_data/word_addr are valid.
word_addr  output  ADDR_W  index of the word on word_data.
busy  output  1  high while the FSM is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, word_data=0, word_valid=0, word_addr=0, busy=0, byte lane counter=0, both synchroniser flops=1.
- Synchroniser: two flops on rxd. The FSM sees only the second flop (rxs).
- Bit counter: counts clk cycles within a bit, cleared on every state change.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rxs=0 -> START.
  - START: at count CLKS_PER_BIT/2-1 (integer division), sample rxs. If 0 -> DATA. If 1 -> IDLE (glitch rejected; no pulses).
  - DATA: sample rxs every CLKS_PER_BIT cycles. Bits shift in LSB first. After the 8th sample -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs. If 1: rx_data<=shift, rx_valid pulse. If 0: frame_err pulse, byte discarded, lane counter unchanged. Either way -> IDLE in the same cycle.
  - Returning to IDLE at mid-stop-bit lets back-to-back frames be caught.
- Timing: rx_valid/frame_err assert in the cycle after the stop sample. The stop sample falls about 9.5 bit-times after the falling edge, plus 2 cycles of synchroniser delay.
- Word packing:
  - On rx_valid, the byte goes to lane cnt (cnt 0..3) and cnt increments.
  - On the 4th byte: word_data is loaded with all four lanes, word_valid pulses one cycle after that rx_valid, and cnt returns to 0.
  - word_addr holds the index of the current word during the word_valid pulse and increments in the cycle after. It wraps from 2**ADDR_W-1 to 0 with no flag.
- Pulse behaviour: word_valid and rx_valid are never stretched, and there is no back-pressure; the consumer must accept in the pulse cycle.
- busy = (state != IDLE), registered.
- Reset mid-frame: the FSM, partial word and lane counter are cleared immediately; no pulse is generated. The next word after reset is word_addr 0.
- A line held low (break) produces one frame_err, then START is re-entered only after rxs returns high and falls again. This needs an IDLE high-seen flag, set on rxs=1 in IDLE.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - Constant BITS_PER_FRAME=8.
  - Helper function for half-bit count.
- Sub-module uart_rx_byte: synchroniser, FSM and shift register, outputs rx_data/rx_valid/frame_err/busy.
- uart_rx_loader: instantiates uart_rx_byte and contains the lane counter, word register and word_addr.

Test Plan:
- Single byte, CLKS_PER_BIT=16: send 0xA5 -> one rx_valid pulse, rx_data=0xA5, no frame_err; pulse within 152..156 cycles of the falling edge.
- Word assembly: send 0x11,0x22,0x33,0x44 back-to-back -> one word_valid with word_data=0x44332211, word_addr=0. Send 4 more bytes -> word_addr=1.
- Glitch and framing: a 3-cycle low pulse on rxd -> no pulses, busy returns to 0. A frame 0x5A with stop bit 0 -> frame_err pulse, rx_data unchanged, lane count unchanged (the next 4 good bytes form one word).
- Wrap, ADDR_W=2: send 5 words -> word_addr sequence 0,1,2,3,0.
- Reset mid-frame: assert reset during DATA of byte 2 of a word -> all outputs 0 immediately. After release, 4 fresh bytes 0xDE,0xAD,0xBE,0xEF -> word_data=0xEFBEADDE, word_addr=0.
- Break: hold rxd low for 40 bit-times -> exactly one frame_err, no rx_valid. After release, a normal byte 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive / word loader path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int BITS_PER_FRAME = 8;

    // Count at which the start bit is re-checked: the middle of the bit.
    function automatic int half_bit_last(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_loader_if.sv
// Serial line in, received bytes and assembled memory words out.
interface uart_rx_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              rxd;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic [31:0]       word_data;
    logic              word_valid;
    logic [ADDR_W-1:0] word_addr;
    logic              busy;

    modport master (
        input  rxd,
        output rx_data, rx_valid, frame_err, word_data, word_valid, word_addr, busy
    );

    modport slave (
        output rxd,
        input  rx_data, rx_valid, frame_err, word_data, word_valid, word_addr, busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: 2-flop synchroniser, bit-timing FSM, shift register.
// Byte/frame_err pulse one cycle after the mid-stop-bit sample; no back-pressure.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rxd,
    output logic [BITS_PER_FRAME-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_last(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(BITS_PER_FRAME - 1);

    logic                      sync1, rxs;
    rx_state_t                 state, state_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic [2:0]                bit_idx, bit_idx_d;
    logic [BITS_PER_FRAME-1:0] shift, shift_d, rx_data_d;
    logic                      high_seen, high_seen_d;
    logic                      rx_valid_d, frame_err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            high_seen <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync1     <= rxd;
            rxs       <= sync1;
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            shift     <= shift_d;
            high_seen <= high_seen_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
            busy      <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt + CNT_W'(1);
        bit_idx_d   = bit_idx;
        shift_d     = shift;
        high_seen_d = high_seen;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                // A falling edge only counts once the line has been seen idle, so a break yields one error.
                if (rxs) begin
                    high_seen_d = 1'b1;
                end else if (high_seen) begin
                    state_d     = START;
                    high_seen_d = 1'b0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    if (!rxs) begin
                        state_d = DATA;
                    end else begin
                        state_d     = IDLE;
                        high_seen_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift[BITS_PER_FRAME-1:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                if (cnt == BIT_LAST) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    high_seen_d = rxs;
                    if (rxs) begin
                        rx_data_d  = shift;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_loader.sv
// UART loader: bytes packed little-endian into 32-bit words with a wrapping word index.
// word_valid one cycle after the 4th rx_valid; pulses only, consumer cannot stall.
module uart_rx_loader
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_loader_if.master bus
);

    logic [BITS_PER_FRAME-1:0]   byte_dat;
    logic                        byte_vld;
    logic [1:0]                  lane;
    logic [3*BITS_PER_FRAME-1:0] partial;
    logic [31:0]                 word;
    logic                        word_vld;
    logic [ADDR_W-1:0]           addr;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk       (clk),
        .reset     (reset),
        .rxd       (bus.rxd),
        .rx_data   (byte_dat),
        .rx_valid  (byte_vld),
        .frame_err (bus.frame_err),
        .busy      (bus.busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane     <= '0;
            partial  <= '0;
            word     <= '0;
            word_vld <= 1'b0;
            addr     <= '0;
        end else begin
            word_vld <= 1'b0;
            // The index stays put for the pulse cycle and advances right after it.
            if (word_vld) addr <= addr + ADDR_W'(1);
            if (byte_vld) begin
                if (lane == 2'd3) begin
                    word     <= {byte_dat, partial};
                    word_vld <= 1'b1;
                    lane     <= '0;
                end else begin
                    partial <= {byte_dat, partial[3*BITS_PER_FRAME-1:BITS_PER_FRAME]};
                    lane    <= lane + 2'd1;
                end
            end
        end
    end

    assign bus.rx_data    = byte_dat;
    assign bus.rx_valid   = byte_vld;
    assign bus.word_data  = word;
    assign bus.word_valid = word_vld;
    assign bus.word_addr  = addr;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Randomized bench for uart_rx_loader with a queue-based byte/word reference model.
module tb_uart_rx_loader;

    localparam int CPB = 16;
    localparam int AW  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_rx_loader_if #(.ADDR_W(AW)) bus ();

    uart_rx_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // observed events
    logic [7:0]     rx_log[$];
    logic [AW+31:0] word_log[$];
    int             fe_cnt    = 0;
    int             rx_cyc    = 0;
    bit             busy_seen = 1'b0;

    // reference model
    logic [7:0]     exp_rx[$];
    logic [AW+31:0] exp_words[$];
    logic [7:0]     m_lanes[$];
    int             exp_fe = 0;
    int             m_addr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_log.push_back(bus.rx_data);
            rx_cyc = cyc;
        end
        if (bus.frame_err) fe_cnt++;
        if (bus.word_valid) word_log.push_back({bus.word_addr, bus.word_data});
        if (bus.busy) busy_seen = 1'b1;
    end

    task automatic model_good(input logic [7:0] b);
        exp_rx.push_back(b);
        m_lanes.push_back(b);
        if (m_lanes.size() == 4) begin
            exp_words.push_back({AW'(m_addr), m_lanes[3], m_lanes[2], m_lanes[1], m_lanes[0]});
            m_addr = (m_addr + 1) % (1 << AW);
            m_lanes.delete();
        end
    endtask

    task automatic idle(input int n);
        bus.rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv);
        logic [9:0] fr;
        fr = {stopv, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rxd = fr[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        bus.rxd = 1'b1;
        if (stopv) model_good(b);
        else exp_fe++;
    endtask

    task automatic apply_reset;
        reset   = 1'b1;
        bus.rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rx_log.delete(); word_log.delete(); fe_cnt = 0; busy_seen = 1'b0;
        exp_rx.delete(); exp_words.delete(); m_lanes.delete(); exp_fe = 0; m_addr = 0;
        idle(2 * CPB);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.word_data, bus.word_valid, bus.word_addr, bus.busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rx_data=%h word_data=%h addr=%0d busy=%b want all 0",
                     bus.rx_data, bus.word_data, bus.word_addr, bus.busy);
        end
        reset = 1'b0;
        idle(3 * CPB);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", bus.busy); end
        total++;
        if (rx_log.size() + fe_cnt + word_log.size() != 0) begin
            bad++; $display("FAIL reset_no_pulses got=%0d events want=0", rx_log.size() + fe_cnt + word_log.size());
        end
    endtask

    task automatic test_single_byte;
        int t0;
        apply_reset();
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(2 * CPB);
        total++;
        if (rx_log.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", rx_log.size()); end
        else begin
            total++;
            if (rx_log[0] !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", rx_log[0]); end
            total++;
            if (rx_cyc - t0 < 152 || rx_cyc - t0 > 156) begin
                bad++; $display("FAIL single_latency got=%0d want=152..156", rx_cyc - t0);
            end
        end
        total++;
        if (fe_cnt != 0) begin bad++; $display("FAIL single_frame_err got=%0d want=0", fe_cnt); end
        total++;
        if (bus.rx_data !== 8'hA5) begin bad++; $display("FAIL single_hold got=%h want=a5", bus.rx_data); end
    endtask

    task automatic test_word;
        logic [7:0] seq[4];
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        apply_reset();
        for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b1);
        idle(2 * CPB);
        total++;
        if (word_log.size() != 1) begin bad++; $display("FAIL word_count got=%0d want=1", word_log.size()); end
        else begin
            total++;
            if (word_log[0] !== {2'd0, 32'h44332211}) begin
                bad++; $display("FAIL word_first got=%h want=%h", word_log[0], {2'd0, 32'h44332211});
            end
        end
        total++;
        if (bus.word_addr !== 2'd1) begin bad++; $display("FAIL word_addr_adv got=%0d want=1", bus.word_addr); end
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1);
        idle(2 * CPB);
        total++;
        if (word_log.size() != 2) begin bad++; $display("FAIL word_count2 got=%0d want=2", word_log.size()); end
        else begin
            total++;
            if (word_log[1] !== exp_words[1]) begin
                bad++; $display("FAIL word_second got=%h want=%h", word_log[1], exp_words[1]);
            end
            total++;
            if (word_log[1][AW+31:32] !== 2'd1) begin
                bad++; $display("FAIL word_second_addr got=%0d want=1", word_log[1][AW+31:32]);
            end
        end
    endtask

    task automatic test_glitch_framing;
        apply_reset();
        bus.rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(2 * CPB);
        total++;
        if (rx_log.size() + fe_cnt + word_log.size() != 0) begin
            bad++; $display("FAIL glitch_pulses got=%0d want=0", rx_log.size() + fe_cnt + word_log.size());
        end
        total++;
        if (busy_seen !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL glitch_busy got seen=%b now=%b want seen=1 now=0", busy_seen, bus.busy);
        end
        send_frame(8'h77, 1'b1);
        send_frame(8'h5A, 1'b0);
        idle(CPB);
        total++;
        if (fe_cnt != 1) begin bad++; $display("FAIL framing_err_count got=%0d want=1", fe_cnt); end
        total++;
        if (bus.rx_data !== 8'h77) begin bad++; $display("FAIL framing_hold got=%h want=77", bus.rx_data); end
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
        idle(2 * CPB);
        total++;
        if (word_log.size() != 1) begin bad++; $display("FAIL framing_word_count got=%0d want=1", word_log.size()); end
        else begin
            total++;
            if (word_log[0] !== exp_words[0]) begin
                bad++; $display("FAIL framing_word got=%h want=%h", word_log[0], exp_words[0]);
            end
        end
    endtask

    task automatic test_wrap;
        apply_reset();
        for (int i = 0; i < 20; i++) send_frame(8'($urandom), 1'b1);
        idle(2 * CPB);
        total++;
        if (word_log.size() != 5) begin bad++; $display("FAIL wrap_count got=%0d want=5", word_log.size()); end
        for (int i = 0; i < 5 && i < word_log.size(); i++) begin
            total++;
            if (word_log[i] !== exp_words[i] || word_log[i][AW+31:32] !== AW'(i % 4)) begin
                bad++; $display("FAIL wrap_word%0d got=%h want=%h", i, word_log[i], exp_words[i]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] seq[4];
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        apply_reset();
        for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
        bus.rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.rxd = 1'($urandom_range(0, 1));
            repeat (CPB) @(posedge clk);
            #1;
        end
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL midframe_busy got=%b want=1", bus.busy); end
        reset = 1'b1;
        #1;
        total++;
        if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.word_data, bus.word_valid, bus.word_addr, bus.busy} !== '0) begin
            bad++;
            $display("FAIL midframe_reset_outputs got rx_data=%h word_data=%h addr=%0d busy=%b want all 0",
                     bus.rx_data, bus.word_data, bus.word_addr, bus.busy);
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        bus.rxd = 1'b1;
        rx_log.delete(); word_log.delete(); fe_cnt = 0;
        exp_rx.delete(); exp_words.delete(); m_lanes.delete(); exp_fe = 0; m_addr = 0;
        idle(2 * CPB);
        for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b1);
        idle(2 * CPB);
        total++;
        if (word_log.size() != 1) begin bad++; $display("FAIL midframe_word_count got=%0d want=1", word_log.size()); end
        else begin
            total++;
            if (word_log[0] !== {2'd0, 32'hEFBEADDE}) begin
                bad++; $display("FAIL midframe_word got=%h want=%h", word_log[0], {2'd0, 32'hEFBEADDE});
            end
        end
    endtask

    task automatic test_break;
        apply_reset();
        bus.rxd = 1'b0;
        repeat (40 * CPB) @(posedge clk);
        #1;
        idle(2 * CPB);
        total++;
        if (fe_cnt != 1) begin bad++; $display("FAIL break_err_count got=%0d want=1", fe_cnt); end
        total++;
        if (rx_log.size() != 0) begin bad++; $display("FAIL break_rx_count got=%0d want=0", rx_log.size()); end
        send_frame(8'h3C, 1'b1);
        idle(2 * CPB);
        total++;
        if (rx_log.size() != 1) begin bad++; $display("FAIL break_after_count got=%0d want=1", rx_log.size()); end
        else begin
            total++;
            if (rx_log[0] !== 8'h3C) begin bad++; $display("FAIL break_after_data got=%h want=3c", rx_log[0]); end
        end
    endtask

    task automatic test_random;
        logic good;
        apply_reset();
        for (int n = 0; n < 16; n++) begin
            good = ($urandom_range(0, 4) != 0);
            send_frame(8'($urandom), good);
            if (!good) idle(CPB);
            else idle($urandom_range(0, CPB));
        end
        idle(2 * CPB);
        total++;
        if (rx_log.size() != exp_rx.size()) begin
            bad++; $display("FAIL rand_rx_count got=%0d want=%0d", rx_log.size(), exp_rx.size());
        end
        for (int i = 0; i < rx_log.size() && i < exp_rx.size(); i++) begin
            total++;
            if (rx_log[i] !== exp_rx[i]) begin bad++; $display("FAIL rand_rx%0d got=%h want=%h", i, rx_log[i], exp_rx[i]); end
        end
        total++;
        if (fe_cnt != exp_fe) begin bad++; $display("FAIL rand_fe_count got=%0d want=%0d", fe_cnt, exp_fe); end
        total++;
        if (word_log.size() != exp_words.size()) begin
            bad++; $display("FAIL rand_word_count got=%0d want=%0d", word_log.size(), exp_words.size());
        end
        for (int i = 0; i < word_log.size() && i < exp_words.size(); i++) begin
            total++;
            if (word_log[i] !== exp_words[i]) begin
                bad++; $display("FAIL rand_word%0d got=%h want=%h", i, word_log[i], exp_words[i]);
            end
        end
        total++;
        if (bus.word_addr !== AW'(m_addr)) begin
            bad++; $display("FAIL rand_addr got=%0d want=%0d", bus.word_addr, m_addr);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rxd = 1'b1;
        test_reset();
        test_single_byte();
        test_word();
        test_glitch_framing();
        test_wrap();
        test_reset_midframe();
        test_break();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
